memory_sdram_word_bridge: RTL
=============================

Name: memory_sdram_word_bridge

Overview:
- Upstream adapter in front of the 16-bit SDRAM controller.
- Accepts 32-bit word accesses with a per-byte write mask from the internal memory bus.
- Splits each access into sequential 16-bit controller transactions.
- The controller has no DQM, so partial-halfword writes are done as read-modify-write on that halfword.

Parameters:
- ADDRESS_WIDTH, 26: number of significant byte-address bits; mem_address[31:ADDRESS_WIDTH] is driven 0.
- LOW_HALF_FIRST, 0: 0 = big-endian order, bits [31:16] at word address and [15:0] at word address+2, high half processed first; 1 = both swapped.

Ports:
- sys.clk  input  1  clock (if_system sys)
- sys.reset  input  1  synchronous, active-high reset (if_system sys)
- bus_request  input  1  level request; held until bus_ack
- bus_ack  output  1  single-cycle completion pulse
- bus_write  input  1  1 = write, 0 = read
- bus_address  input  32  byte address; bits [1:0] ignored
- bus_wmask  input  4  byte enables; bit3 = [31:24] … bit0 = [7:0]
- bus_wdata  input  32  write data
- bus_rdata  output  32  read data
- mem_request  output  1  to controller request
- mem_ack  input  1  from controller ack
- mem_write  output  1  to controller write
- mem_address  output  32  to controller address (halfword aligned, bit0 = 0)
- mem_wdata  output  16  to controller wdata
- mem_rdata  input  16  from controller rdata; valid in the mem_ack cycle of a read

Behaviour:
- Reset values: bus_ack=0, bus_rdata=0, mem_request=0, mem_write=0, mem_address=0, mem_wdata=0, state=S_IDLE.
- All outputs are registered.
- Accept:
  - In S_IDLE with bus_request=1, latch write, {address[ADDRESS_WIDTH-1:2],2'b00}, wmask and wdata.
  - Half index h: 0 = first half, 1 = second half; offsets +0 and +2.
- Per half, mask pair m = wmask bits of that half:
  - read: issue READ.
  - write, m=00: skip, no mem traffic.
  - write, m=11: issue WRITE with latched half data.
  - write, m=01 or 10: issue READ, merge enabled bytes over returned data, then issue WRITE of the merged value.
- States:
  - S_IDLE
  - S_READ: read for data or for RMW
  - S_WRITE
  - S_NEXT: select the next half or finish
  - S_DONE: pulse bus_ack
- Transitions:
  - IDLE→NEXT on accept.
  - NEXT→READ / WRITE / NEXT(skip) / DONE, decided from h and m.
  - READ→WRITE (RMW) or NEXT on mem_ack.
  - WRITE→NEXT on mem_ack.
  - DONE→IDLE.
- Downstream handshake:
  - mem_request is set on entry to READ/WRITE.
  - On the edge where mem_ack=1 is sampled, mem_request is cleared or replaced by the next access. The same access is never re-presented.
  - mem_address, mem_write and mem_wdata are stable while mem_request=1.
- Read data:
  - Captured into the corresponding half of bus_rdata on mem_ack.
  - bus_rdata is valid in the bus_ack cycle and held until the next accepted read.
  - Writes do not modify bus_rdata.
- Upstream handshake:
  - bus_ack is asserted exactly one cycle, in S_DONE.
  - The requester drops or changes bus_request on that edge.
  - bus_request is not sampled outside S_IDLE.
- Zero-mask write: completes with bus_ack 2 cycles after accept, no mem_request.
- Address wrap: +2 computed within ADDRESS_WIDTH bits. The word is aligned, so there is no carry into bit ADDRESS_WIDTH.
- Reset mid-operation: immediate return to S_IDLE, all outputs to reset values. The controller shares sys.reset, so no transaction is left dangling.
- Spurious mem_ack outside READ/WRITE is ignored.

Test Plan:
- Read 0x0000_1000, controller returns 0x1234 then 0x5678 → mem_address 0x1000 then 0x1002, both mem_write=0; single bus_ack; bus_rdata=0x1234_5678.
- Write 0x0000_2000, data 0xAABB_CCDD, mask 1111 → WRITE 0x2000=0xAABB, then WRITE 0x2002=0xCCDD; no reads; one bus_ack.
- Write 0x0000_3000, data 0x11223344, mask 0100, memory at 0x3000 holds 0xEEFF → READ 0x3000, then WRITE 0x3000=0xEE22; half 0x3002 untouched; bus_rdata unchanged.
- Write with mask 0000 → no mem_request; bus_ack exactly 2 cycles after accept.
- Back-to-back: read followed immediately by a write, with the controller ack delayed 3 cycles → mem_request never high for the same access after its mem_ack; each bus access gets one bus_ack.
- Reset asserted while waiting on the second-half mem_ack → next cycle mem_request=0, bus_ack=0, state IDLE; a fresh read afterwards completes correctly.

Source files
------------

// File: rtl/memory_sdram_word_bridge.sv
// Bridges 32-bit masked word accesses onto a 16-bit SDRAM controller port.
// Partial-halfword writes become read-modify-write because the controller lacks DQM.
module memory_sdram_word_bridge #(
    parameter int ADDRESS_WIDTH  = 26,
    parameter int LOW_HALF_FIRST = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_request,
    output logic        bus_ack,
    input  logic        bus_write,
    input  logic [31:0] bus_address,
    input  logic [3:0]  bus_wmask,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        mem_request,
    input  logic        mem_ack,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic FIRST_IS_LOW = (LOW_HALF_FIRST != 0);

    state_t                   state, state_d;
    logic                     wr_q, wr_d;
    logic [ADDRESS_WIDTH-1:2] word_q, word_d;
    logic [3:0]               wmask_q, wmask_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [1:0]               ptr_q, ptr_d;

    logic                     bus_ack_d;
    logic [31:0]              bus_rdata_d;
    logic                     mem_request_d;
    logic                     mem_write_d;
    logic [31:0]              mem_address_d;
    logic [15:0]              mem_wdata_d;

    logic                     cur_high;
    logic [1:0]               cur_m;
    logic [15:0]              cur_data;
    logic [15:0]              merged;
    logic                     cur_skip;
    logic                     skip_first;
    logic                     skip_second;
    logic                     finished;

    logic                     unused_addr_bits;
    assign unused_addr_bits = ^{bus_address[31:ADDRESS_WIDTH], bus_address[1:0]};

    // ptr_q counts halves already handled (0, 1, or 2 = all done)
    always_comb begin
        cur_high    = (ptr_q[0] == FIRST_IS_LOW);
        cur_m       = cur_high ? wmask_q[3:2] : wmask_q[1:0];
        cur_data    = cur_high ? wdata_q[31:16] : wdata_q[15:0];
        cur_skip    = wr_q && (cur_m == 2'b00);
        skip_first  = wr_q && ((FIRST_IS_LOW ? wmask_q[1:0] : wmask_q[3:2]) == 2'b00);
        skip_second = wr_q && ((FIRST_IS_LOW ? wmask_q[3:2] : wmask_q[1:0]) == 2'b00);
        merged      = {cur_m[1] ? cur_data[15:8] : mem_rdata[15:8],
                       cur_m[0] ? cur_data[7:0]  : mem_rdata[7:0]};
        // Finishing early when every remaining half is a skip keeps the
        // all-zero-mask write at two cycles from accept to bus_ack.
        finished    = (ptr_q == 2'd2) ||
                      ((ptr_q == 2'd1) && skip_second) ||
                      ((ptr_q == 2'd0) && skip_first && skip_second);
    end

    always_comb begin
        state_d       = state;
        wr_d          = wr_q;
        word_d        = word_q;
        wmask_d       = wmask_q;
        wdata_d       = wdata_q;
        ptr_d         = ptr_q;
        bus_ack_d     = 1'b0;
        bus_rdata_d   = bus_rdata;
        mem_request_d = mem_request;
        mem_write_d   = mem_write;
        mem_address_d = mem_address;
        mem_wdata_d   = mem_wdata;

        case (state)
            S_IDLE: begin
                if (bus_request) begin
                    wr_d    = bus_write;
                    word_d  = bus_address[ADDRESS_WIDTH-1:2];
                    wmask_d = bus_wmask;
                    wdata_d = bus_wdata;
                    ptr_d   = 2'd0;
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (finished) begin
                    bus_ack_d = 1'b1;
                    state_d   = S_DONE;
                end else if (cur_skip) begin
                    ptr_d = ptr_q + 2'd1;
                end else begin
                    mem_request_d                   = 1'b1;
                    mem_address_d                   = '0;
                    mem_address_d[ADDRESS_WIDTH-1:2] = word_q;
                    mem_address_d[1]                = ptr_q[0];
                    if (wr_q && (cur_m == 2'b11)) begin
                        mem_write_d = 1'b1;
                        mem_wdata_d = cur_data;
                        state_d     = S_WRITE;
                    end else begin
                        mem_write_d = 1'b0;
                        state_d     = S_READ;
                    end
                end
            end

            S_READ: begin
                if (mem_ack) begin
                    if (wr_q) begin
                        // RMW: the write replaces the read on the same edge
                        mem_write_d = 1'b1;
                        mem_wdata_d = merged;
                        state_d     = S_WRITE;
                    end else begin
                        if (cur_high) begin
                            bus_rdata_d[31:16] = mem_rdata;
                        end else begin
                            bus_rdata_d[15:0] = mem_rdata;
                        end
                        mem_request_d = 1'b0;
                        ptr_d         = ptr_q + 2'd1;
                        state_d       = S_NEXT;
                    end
                end
            end

            S_WRITE: begin
                if (mem_ack) begin
                    mem_request_d = 1'b0;
                    mem_write_d   = 1'b0;
                    ptr_d         = ptr_q + 2'd1;
                    state_d       = S_NEXT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_q        <= 1'b0;
            word_q      <= '0;
            wmask_q     <= '0;
            wdata_q     <= '0;
            ptr_q       <= '0;
            bus_ack     <= 1'b0;
            bus_rdata   <= '0;
            mem_request <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_d;
            wr_q        <= wr_d;
            word_q      <= word_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            ptr_q       <= ptr_d;
            bus_ack     <= bus_ack_d;
            bus_rdata   <= bus_rdata_d;
            mem_request <= mem_request_d;
            mem_write   <= mem_write_d;
            mem_address <= mem_address_d;
            mem_wdata   <= mem_wdata_d;
        end
    end

endmodule
